// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game blocks (also imported by obstacle_gen).
// Optional high-score feature: DINO_HIGH_SCORE_EN.
package dino_pkg;

    localparam int unsigned LANE_W           = 8;
    localparam int unsigned DINO_COL_DEFAULT = 0;
    localparam int unsigned AIR_CNT_W        = 4;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_AIR  = 2'd1,
        ST_OVER = 2'd2
    } dino_state_e;

endpackage

// File: rtl/dino_collision_ctrl_if.sv
// Game-step inputs and status outputs of dino_collision_ctrl.
// hi_score exists only when DINO_HIGH_SCORE_EN is defined.
interface dino_collision_ctrl_if
    import dino_pkg::*;
#(
    parameter int unsigned SCORE_DIGITS = 4
);
    localparam int unsigned SCORE_W = 4 * SCORE_DIGITS;

    logic               tick;
    logic [LANE_W-1:0]  down;
    logic               jump;
    logic               restart;
    logic               airborne;
    logic               game_over;
    logic               collision;
    logic [SCORE_W-1:0] score;
`ifdef DINO_HIGH_SCORE_EN
    logic [SCORE_W-1:0] hi_score;
`endif

    modport master (
        output tick, down, jump, restart,
`ifdef DINO_HIGH_SCORE_EN
        input  hi_score,
`endif
        input  airborne, game_over, collision, score
    );

    modport slave (
        input  tick, down, jump, restart,
`ifdef DINO_HIGH_SCORE_EN
        output hi_score,
`endif
        output airborne, game_over, collision, score
    );

endinterface

// File: rtl/dino_collision_ctrl_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; all-9s wraps to zero.
module bcd_counter
    import dino_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    output logic [4*DIGITS-1:0] value
);
    localparam int unsigned VAL_W = 4 * DIGITS;

    logic [VAL_W-1:0] value_q;
    logic [VAL_W-1:0] value_d;
    logic             carry;
    bcd_digit_t       digit;

    // Ripple carry: a digit advances only while every lower digit rolls 9 -> 0.
    always_comb begin
        value_d = value_q;
        carry   = inc;
        digit   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = value_q[4*i +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    value_d[4*i +: 4] = 4'd0;
                end else begin
                    value_d[4*i +: 4] = digit + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (clr) begin
            value_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/dino_collision_ctrl.sv
// Dino jump FSM, collision detection and BCD scoring on each game tick.
// Define DINO_HIGH_SCORE_EN to add the hi_score register.
module dino_collision_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned DINO_COL     = DINO_COL_DEFAULT,
    parameter int unsigned JUMP_TICKS   = 3,
    parameter int unsigned SCORE_DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dino_collision_ctrl_if.slave bus
);
    localparam int unsigned SCORE_W = 4 * SCORE_DIGITS;
    localparam logic [2:0]  COL_IDX = 3'(DINO_COL);

    dino_state_e          state_q, state_d;
    logic [AIR_CNT_W-1:0] air_cnt_q, air_cnt_d;
    logic                 jump_q;
    logic                 airborne_q, game_over_q, collision_q;
    logic                 collision_d;
    logic                 score_inc, score_clr;
    logic                 jump_rise;
    logic                 obs;
    logic [SCORE_W-1:0]   score_w;

    assign jump_rise = bus.jump & ~jump_q;
    assign obs       = bus.down[COL_IDX];

    // Tick is judged against the pre-tick state; a colliding tick drops a same-cycle jump.
    always_comb begin
        state_d     = state_q;
        air_cnt_d   = air_cnt_q;
        collision_d = 1'b0;
        score_inc   = 1'b0;
        score_clr   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.tick && obs) begin
                    state_d     = ST_OVER;
                    collision_d = 1'b1;
                end else if (jump_rise) begin
                    state_d   = ST_AIR;
                    air_cnt_d = AIR_CNT_W'(JUMP_TICKS);
                end
            end
            ST_AIR: begin
                if (bus.tick) begin
                    score_inc = obs;
                    air_cnt_d = air_cnt_q - AIR_CNT_W'(1);
                    if (air_cnt_q == AIR_CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_OVER: begin
                if (bus.restart) begin
                    state_d   = ST_RUN;
                    air_cnt_d = '0;
                    score_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            air_cnt_q   <= '0;
            jump_q      <= 1'b0;
            airborne_q  <= 1'b0;
            game_over_q <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            air_cnt_q   <= air_cnt_d;
            jump_q      <= bus.jump;
            airborne_q  <= (state_d == ST_AIR);
            game_over_q <= (state_d == ST_OVER);
            collision_q <= collision_d;
        end
    end

    bcd_counter #(
        .DIGITS(SCORE_DIGITS)
    ) u_score (
        .clk  (clk),
        .reset(reset),
        .inc  (score_inc),
        .clr  (score_clr),
        .value(score_w)
    );

    assign bus.airborne  = airborne_q;
    assign bus.game_over = game_over_q;
    assign bus.collision = collision_q;
    assign bus.score     = score_w;

`ifdef DINO_HIGH_SCORE_EN
    logic [SCORE_W-1:0] hi_q;

    // Packed BCD orders the same as unsigned binary, so a plain compare is a magnitude compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
        end else if (state_q != ST_OVER && state_d == ST_OVER && score_w > hi_q) begin
            hi_q <= score_w;
        end
    end

    assign bus.hi_score = hi_q;
`endif

endmodule

// File: tb/tb_dino_collision_ctrl.sv
// Scoreboard bench for dino_collision_ctrl: directed game scenarios plus random play
// against a decimal-integer reference model.
module tb_dino_collision_ctrl;
    import dino_pkg::*;

    localparam int COL     = 0;
    localparam int JT      = 3;
    localparam int DIG     = 4;
    localparam int SW      = 4 * DIG;
    localparam int MODULUS = 10000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dino_collision_ctrl_if #(.SCORE_DIGITS(DIG)) bus ();

    dino_collision_ctrl #(
        .DINO_COL    (COL),
        .JUMP_TICKS  (JT),
        .SCORE_DIGITS(DIG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic          air;
        logic          over;
        logic          coll;
        logic [SW-1:0] score;
        logic [SW-1:0] hi;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: remaining air ticks (0 = grounded), game-over flag, decimal scores.
    bit m_over;
    int m_air;
    int m_score;
    int m_hi;
    bit m_prev_jump;

    function automatic logic [SW-1:0] to_bcd(input int v);
        logic [SW-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_over      = 1'b0;
        m_air       = 0;
        m_score     = 0;
        m_hi        = 0;
        m_prev_jump = 1'b0;
    endtask

    // One clock of stimulus; the model predicts the outputs visible after the next edge.
    task automatic cyc(input bit t, input logic [7:0] d, input bit j, input bit r);
        bit   rise;
        bit   obs;
        exp_t e;
        logic [7:0] dd;
        @(negedge clk);
        bus.tick    = t;
        bus.down    = d;
        bus.jump    = j;
        bus.restart = r;
        dd   = d;
        rise = j && !m_prev_jump;
        m_prev_jump = j;
        obs  = dd[COL];
        e.coll = 1'b0;
        if (m_over) begin
            if (r) begin
                m_over  = 1'b0;
                m_score = 0;
                m_air   = 0;
            end
        end else if (m_air > 0) begin
            if (t) begin
                if (obs) m_score = (m_score + 1) % MODULUS;
                m_air = m_air - 1;
            end
        end else if (t && obs) begin
            m_over = 1'b1;
            e.coll = 1'b1;
            if (m_score > m_hi) m_hi = m_score;
        end else if (rise) begin
            m_air = JT;
        end
        e.air   = (m_air > 0);
        e.over  = m_over;
        e.score = to_bcd(m_score);
        e.hi    = to_bcd(m_hi);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        bus.tick    = 1'b0;
        bus.down    = '0;
        bus.jump    = 1'b0;
        bus.restart = 1'b0;
        #1;
        n_checks++;
        if (bus.airborne !== 1'b0 || bus.game_over !== 1'b0 || bus.collision !== 1'b0 ||
            bus.score !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs t=%0t got air=%0b over=%0b coll=%0b score=%h, expected all 0",
                     $time, bus.airborne, bus.game_over, bus.collision, bus.score);
        end
`ifdef DINO_HIGH_SCORE_EN
        n_checks++;
        if (bus.hi_score !== '0) begin
            n_fail++;
            $display("FAIL reset_hi_score t=%0t got %h expected 0", $time, bus.hi_score);
        end
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: outputs are valid every cycle; compare each one that has a prediction queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.airborne !== e.air || bus.game_over !== e.over ||
                    bus.collision !== e.coll || bus.score !== e.score) begin
                    n_fail++;
                    $display("FAIL step_outputs t=%0t got air=%0b over=%0b coll=%0b score=%h expected air=%0b over=%0b coll=%0b score=%h",
                             $time, bus.airborne, bus.game_over, bus.collision, bus.score,
                             e.air, e.over, e.coll, e.score);
                end
`ifdef DINO_HIGH_SCORE_EN
                n_checks++;
                if (bus.hi_score !== e.hi) begin
                    n_fail++;
                    $display("FAIL hi_score t=%0t got %h expected %h", $time, bus.hi_score, e.hi);
                end
`endif
            end
        end
    end

    initial begin
        bit rj;
        bus.tick    = 1'b0;
        bus.down    = '0;
        bus.jump    = 1'b0;
        bus.restart = 1'b0;
        model_reset();
        do_reset();

        // Game 1 ends at 5, game 2 ends at 2 (hi_score keeps 5 when present).
        cyc(0, 8'h00, 1, 0);
        repeat (3) cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 1, 0);
        repeat (2) cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h00, 0, 0);
        cyc(1, 8'h01, 0, 0);
        repeat (2) cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 0);
        repeat (2) cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h00, 0, 0);
        cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 0, 1);

        // Ten empty ticks.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'h00, 0, 0);
            cyc(0, 8'hFE, 0, 0);
        end

        // Grounded collision; later ticks are frozen out.
        cyc(1, 8'h01, 0, 0);
        repeat (3) cyc(1, 8'hFF, 0, 0);
        cyc(0, 8'h00, 0, 1);

        // Jump over three obstacles, then collide on the fourth.
        cyc(0, 8'h00, 1, 0);
        repeat (3) cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 0, 1);

        // Held jump gives a single air period.
        cyc(0, 8'h00, 1, 0);
        repeat (20) cyc(1, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        repeat (3) cyc(1, 8'h00, 0, 0);

        // Same-cycle tick and jump edge, with and without an obstacle.
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h01, 1, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h00, 1, 0);
        repeat (3) cyc(1, 8'h00, 0, 0);

        // Random play.
        rj = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rj = ~rj;
            cyc(bit'($urandom_range(0, 1)), 8'($urandom), rj,
                ($urandom_range(0, 7) == 0));
        end

        // Score 9999 then wrap to 0000.
        do_reset();
        for (int i = 0; i < 3333; i++) begin
            cyc(0, 8'h00, 1, 0);
            repeat (3) cyc(1, 8'h01, 0, 0);
        end
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h01, 0, 0);
        repeat (2) cyc(1, 8'h00, 0, 0);

        // Reset asserted mid-jump.
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h00, 0, 0);
        do_reset();
        repeat (2) cyc(1, 8'h00, 0, 0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
